writeback_arbiter: RTL and testbench

//  Write-side master for the 32x32 register file: merges ALU results and load/long-latency results

---
 rtl/rv_pkg.sv | 10 +
 rtl/rf_bypass.sv | 12 +
 rtl/writeback_arbiter.sv | 60 ++++++
 tb/tb_writeback_arbiter.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/rv_pkg.sv
// rv_pkg: register-file widths and the writeback request type
package rv_pkg;
  localparam int XLEN = 32;
  localparam int REG_ADDR_W = 5;
  typedef logic [REG_ADDR_W-1:0] reg_addr_t;
  typedef struct packed {
    reg_addr_t       rd;
    logic [XLEN-1:0] data;
  } wb_req_t;
endpackage

// File: rtl/rf_bypass.sv
// rf_bypass: one read-operand mux forwarding the registered writeback over the raw file value
module rf_bypass
  import rv_pkg::*;
(
  input  reg_addr_t       rs_addr,
  input  logic [XLEN-1:0] rf_data,
  input  wb_req_t         wb,
  input  logic            wb_we,
  output logic [XLEN-1:0] rs_data
);
  always_comb rs_data = (rs_addr == '0) ? '0 : (wb_we && wb.rd == rs_addr) ? wb.data : rf_data;
endmodule

// File: rtl/writeback_arbiter.sv
// writeback_arbiter: merges ALU and mem results onto the register file write port, with read bypass
module writeback_arbiter
  import rv_pkg::*;
#(
  parameter int STARVE_LIMIT = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  alu_valid,
  output logic                  alu_ready,
  input  logic [REG_ADDR_W-1:0] alu_rd,
  input  logic [XLEN-1:0]       alu_data,
  input  logic                  mem_valid,
  output logic                  mem_ready,
  input  logic [REG_ADDR_W-1:0] mem_rd,
  input  logic [XLEN-1:0]       mem_data,
  output logic [REG_ADDR_W-1:0] rf_rd_addr,
  output logic [XLEN-1:0]       rf_rd_data,
  output logic                  rf_reg_write,
  input  logic [REG_ADDR_W-1:0] rs1_addr,
  input  logic [REG_ADDR_W-1:0] rs2_addr,
  input  logic [XLEN-1:0]       rs1_rf_data,
  input  logic [XLEN-1:0]       rs2_rf_data,
  output logic [XLEN-1:0]       rs1_data,
  output logic [XLEN-1:0]       rs2_data
);
  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);
  if (STARVE_LIMIT < 1 || STARVE_LIMIT > 15) begin : g_bad_limit
    $error("STARVE_LIMIT must be in 1..15");
  end
  logic [3:0] starve_cnt_q, starve_cnt_d;
  wb_req_t    out_q, out_d;
  logic       we_q, we_d;
  logic       mem_wins;
  always_comb begin
    mem_wins     = mem_valid && (!alu_valid || starve_cnt_q == LIMIT);
    mem_ready    = rst_n && mem_wins;
    alu_ready    = rst_n && alu_valid && !mem_wins;
    starve_cnt_d = (!mem_valid || mem_ready) ? '0 : (starve_cnt_q == LIMIT) ? LIMIT : starve_cnt_q + 4'd1;
    out_d        = mem_ready ? '{rd: mem_rd, data: mem_data} : alu_ready ? '{rd: alu_rd, data: alu_data} : out_q;
    we_d         = (mem_ready && mem_rd != '0) || (alu_ready && alu_rd != '0);
    // a write registered just before reset is dropped in the reset cycle itself
    rf_reg_write = we_q && rst_n;
    rf_rd_addr   = out_q.rd;
    rf_rd_data   = out_q.data;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      starve_cnt_q <= '0;
      out_q        <= '0;
      we_q         <= 1'b0;
    end else begin
      starve_cnt_q <= starve_cnt_d;
      out_q        <= out_d;
      we_q         <= we_d;
    end
  end
  rf_bypass u_byp1 (.rs_addr(rs1_addr), .rf_data(rs1_rf_data), .wb(out_q), .wb_we(rf_reg_write), .rs_data(rs1_data));
  rf_bypass u_byp2 (.rs_addr(rs2_addr), .rf_data(rs2_rf_data), .wb(out_q), .wb_we(rf_reg_write), .rs_data(rs2_data));
endmodule

// File: tb/tb_writeback_arbiter.sv
// tb_writeback_arbiter: directed and random checks of writeback_arbiter against a register-array model
module tb_writeback_arbiter;
  localparam int LIMIT = 4;
  logic        clk, rst_n;
  logic        alu_valid, alu_ready, mem_valid, mem_ready, rf_reg_write;
  logic [4:0]  alu_rd, mem_rd, rf_rd_addr, rs1_addr, rs2_addr;
  logic [31:0] alu_data, mem_data, rf_rd_data, rs1_rf_data, rs2_rf_data, rs1_data, rs2_data;
  logic [31:0] rf [32];
  logic [31:0] gold [32];
  int          n_cmp, n_bad, n_dut_wr, n_exp_wr, m_loss;
  logic        pend_v, chk_en, mg, ag, alu_hold, mem_hold;
  logic [4:0]  m_addr;
  logic [31:0] m_data;

  writeback_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
    .clk(clk), .rst_n(rst_n),
    .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_rd(alu_rd), .alu_data(alu_data),
    .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_rd(mem_rd), .mem_data(mem_data),
    .rf_rd_addr(rf_rd_addr), .rf_rd_data(rf_rd_data), .rf_reg_write(rf_reg_write),
    .rs1_addr(rs1_addr), .rs2_addr(rs2_addr), .rs1_rf_data(rs1_rf_data), .rs2_rf_data(rs2_rf_data),
    .rs1_data(rs1_data), .rs2_data(rs2_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // the register file itself: written only by the DUT, no write-through
  assign rs1_rf_data = rf[rs1_addr];
  assign rs2_rf_data = rf[rs2_addr];
  always @(posedge clk) if (rf_reg_write) begin
    rf[rf_rd_addr] <= rf_rd_data;
    n_dut_wr <= n_dut_wr + 1;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
    end
  endtask

  // model: gold holds committed architectural values; pend_v/m_addr/m_data is the beat on rf_*
  always @(posedge clk) begin
    if (!rst_n) begin
      pend_v = 0; m_loss = 0; m_addr = 0; m_data = 0;
    end else begin
      if (pend_v && m_addr != 0) begin
        gold[m_addr] = m_data;
        n_exp_wr++;
      end
      mg = mem_valid && (!alu_valid || m_loss >= LIMIT);
      ag = alu_valid && !mg;
      if (mg) begin m_addr = mem_rd; m_data = mem_data; end
      else if (ag) begin m_addr = alu_rd; m_data = alu_data; end
      pend_v = mg || ag;
      m_loss = (mem_valid && !mg) ? ((m_loss + 1 > LIMIT) ? LIMIT : m_loss + 1) : 0;
    end
  end

  function automatic logic [31:0] operand(input logic [4:0] a);
    if (a == 0) return 0;
    if (rst_n && pend_v && m_addr != 0 && m_addr == a) return m_data;
    return gold[a];
  endfunction

  always @(negedge clk) if (chk_en) begin
    logic e_mem, e_alu;
    e_mem = rst_n && mem_valid && (!alu_valid || m_loss >= LIMIT);
    e_alu = rst_n && alu_valid && !(mem_valid && (!alu_valid || m_loss >= LIMIT));
    chk("mdl_mem_ready", 32'(mem_ready), 32'(e_mem));
    chk("mdl_alu_ready", 32'(alu_ready), 32'(e_alu));
    chk("mdl_reg_write", 32'(rf_reg_write), 32'(rst_n && pend_v && m_addr != 0));
    chk("mdl_rd_addr", 32'(rf_rd_addr), 32'(m_addr));
    chk("mdl_rd_data", rf_rd_data, m_data);
    chk("mdl_rs1", rs1_data, operand(rs1_addr));
    chk("mdl_rs2", rs2_data, operand(rs2_addr));
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    alu_valid = 0; mem_valid = 0; alu_rd = 0; mem_rd = 0; alu_data = 0; mem_data = 0;
  endtask

  initial begin
    n_cmp = 0; n_bad = 0; n_dut_wr = 0; n_exp_wr = 0; chk_en = 0;
    pend_v = 0; m_loss = 0; m_addr = 0; m_data = 0;
    for (int i = 0; i < 32; i++) begin rf[i] = 0; gold[i] = 0; end
    idle();
    rs1_addr = 0; rs2_addr = 0;
    rst_n = 0;
    alu_valid = 1; alu_rd = 1; alu_data = 32'h11;
    cyc();
    chk_en = 1;
    @(negedge clk);
    chk("rst_we", 32'(rf_reg_write), 0);
    chk("rst_addr", 32'(rf_rd_addr), 0);
    chk("rst_data", rf_rd_data, 0);
    chk("rst_alu_ready", 32'(alu_ready), 0);
    cyc();
    rst_n = 1;
    idle();
    cyc();
    // single ALU beat
    alu_valid = 1; alu_rd = 5; alu_data = 32'hDEADBEEF;
    @(negedge clk);
    chk("t1_ready", 32'(alu_ready), 1);
    cyc();
    idle();
    @(negedge clk);
    chk("t1_we", 32'(rf_reg_write), 1);
    chk("t1_addr", 32'(rf_rd_addr), 5);
    chk("t1_data", rf_rd_data, 32'hDEADBEEF);
    cyc();
    @(negedge clk);
    chk("t1_we_off", 32'(rf_reg_write), 0);
    cyc();
    // starvation: ALU wins four times, then mem, then ALU again
    mem_valid = 1; mem_rd = 9; mem_data = 32'h99;
    for (int i = 0; i < 6; i++) begin
      alu_valid = 1; alu_rd = 5'(10 + i); alu_data = 32'(100 + i);
      @(negedge clk);
      chk($sformatf("t2_alu_rdy%0d", i), 32'(alu_ready), (i != 4) ? 1 : 0);
      chk($sformatf("t2_mem_rdy%0d", i), 32'(mem_ready), (i == 4) ? 1 : 0);
      if (i == 5) chk("t2_mem_out", 32'(rf_rd_addr), 9);
      cyc();
    end
    idle();
    cyc();
    // rd==0 mem beat
    mem_valid = 1; mem_rd = 0; mem_data = 32'h1234;
    @(negedge clk);
    chk("t3_ready", 32'(mem_ready), 1);
    cyc();
    idle();
    rs1_addr = 0;
    @(negedge clk);
    chk("t3_we", 32'(rf_reg_write), 0);
    chk("t3_data", rf_rd_data, 32'h1234);
    chk("t3_x0", rs1_data, 0);
    cyc();
    // bypass of an in-flight write, then the same value from the file
    alu_valid = 1; alu_rd = 7; alu_data = 32'hA5A5A5A5;
    cyc();
    idle();
    rs1_addr = 7; rs2_addr = 7;
    @(negedge clk);
    chk("t4_raw", rs1_rf_data, 0);
    chk("t4_rs1_byp", rs1_data, 32'hA5A5A5A5);
    chk("t4_rs2_byp", rs2_data, 32'hA5A5A5A5);
    cyc();
    @(negedge clk);
    chk("t4_rs1_file", rs1_data, 32'hA5A5A5A5);
    cyc();
    // reset right after accepting rd=3 drops that write
    alu_valid = 1; alu_rd = 3; alu_data = 32'h33; rs1_addr = 3;
    cyc();
    rst_n = 0;
    mem_valid = 1; mem_rd = 3; mem_data = 32'h77;
    @(negedge clk);
    chk("t5_we_rst", 32'(rf_reg_write), 0);
    chk("t5_alu_rdy", 32'(alu_ready), 0);
    chk("t5_mem_rdy", 32'(mem_ready), 0);
    chk("t5_rs1_rst", rs1_data, 0);
    cyc();
    rst_n = 1;
    idle();
    @(negedge clk);
    chk("t5_we_after", 32'(rf_reg_write), 0);
    cyc();
    @(negedge clk);
    chk("t5_x3", rs1_data, 0);
    // random stress; a source that was refused holds its beat
    alu_hold = 0; mem_hold = 0;
    for (int i = 0; i < 600; i++) begin
      cyc();
      rst_n = ($urandom_range(0, 59) != 0);
      if (!alu_hold) begin
        alu_valid = ($urandom_range(0, 3) != 0);
        alu_rd = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom);
        alu_data = $urandom;
      end
      if (!mem_hold) begin
        mem_valid = ($urandom_range(0, 2) != 0);
        mem_rd = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom);
        mem_data = $urandom;
      end
      rs1_addr = 5'($urandom);
      rs2_addr = ($urandom_range(0, 1) != 0) ? alu_rd : 5'($urandom);
      @(negedge clk);
      alu_hold = alu_valid && !alu_ready;
      mem_hold = mem_valid && !mem_ready;
    end
    cyc();
    rst_n = 1;
    idle();
    cyc();
    cyc();
    cyc();
    for (int i = 1; i < 32; i++) chk($sformatf("final_x%0d", i), rf[i], gold[i]);
    chk("write_count", 32'(n_dut_wr), 32'(n_exp_wr));
    chk_en = 0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
